// File: rtl/stopwatch_control.sv
// Run/stop/clear controller: synchronises and debounces three buttons, then drives an
// IDLE/RUN/PAUSE FSM that produces the timer count enable and a one-cycle clear pulse.
module stopwatch_control #(
  parameter int DB_COUNT = 250000,
  parameter int CW       = $clog2(DB_COUNT)
) (
  input  logic       SysClk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  output logic       CEn,
  output logic       ClrOut,
  output logic       Running,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_t;

  localparam int NumBtn = 3;
  localparam logic [CW-1:0] CntLast = CW'(DB_COUNT - 1);

  // Channel order: 0 Start, 1 Stop, 2 Clear.
  logic [NumBtn-1:0] w_raw;
  logic [NumBtn-1:0] r_s1;
  logic [NumBtn-1:0] r_s2;
  logic [NumBtn-1:0] r_stable;
  logic [NumBtn-1:0] r_stable_d;
  logic [CW-1:0]     r_cnt [NumBtn];
  logic [NumBtn-1:0] w_press;

  logic   w_start_p;
  logic   w_stop_p;
  logic   w_clear_p;
  state_t r_state;
  logic   r_clr;

  assign w_raw = {Clear, Stop, Start};

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1       <= w_raw;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NumBtn; i++) begin
        // Any return to the accepted level restarts the hold count.
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_press   = r_stable & ~r_stable_d;
  assign w_start_p = w_press[0];
  assign w_stop_p  = w_press[1];
  assign w_clear_p = w_press[2];

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= StIdle;
      r_clr   <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        StIdle: begin
          // Start wins over a simultaneous clear; the timer is already cleared in IDLE.
          if (w_start_p) begin
            r_state <= StRun;
          end else if (w_clear_p) begin
            r_clr <= 1'b1;
          end
        end
        StRun: begin
          if (w_stop_p) begin
            r_state <= StPause;
          end
        end
        StPause: begin
          if (w_clear_p) begin
            r_state <= StIdle;
            r_clr   <= 1'b1;
          end else if (w_start_p) begin
            r_state <= StRun;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign State   = r_state;
  assign CEn     = (r_state == StRun);
  assign Running = CEn;
  assign ClrOut  = r_clr;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with DB_COUNT=4: table of per-cycle vectors plus
// hand-written asynchronous reset sequences.
module tb_stopwatch_control;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SP = 2'b10;

  logic       SysClk;
  logic       Reset_n;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic       CEn;
  logic       ClrOut;
  logic       Running;
  logic [1:0] State;

  int checks;
  int failures;

  typedef struct {
    logic       st;
    logic       sp;
    logic       cl;
    logic [1:0] state;
    logic       clr;
  } vec_t;

  vec_t vecs[$];

  stopwatch_control #(
    .DB_COUNT(4)
  ) dut (
    .SysClk (SysClk),
    .Reset_n(Reset_n),
    .Start  (Start),
    .Stop   (Stop),
    .Clear  (Clear),
    .CEn    (CEn),
    .ClrOut (ClrOut),
    .Running(Running),
    .State  (State)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  task automatic push(input logic st, input logic sp, input logic cl, input logic [1:0] state,
                      input logic clr, input int n);
    vec_t v;
    v.st = st;
    v.sp = sp;
    v.cl = cl;
    v.state = state;
    v.clr = clr;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] es, input logic ec);
    logic er;
    er = (es == SR);
    checks++;
    if (State !== es || CEn !== er || Running !== er || ClrOut !== ec) begin
      failures++;
      $display("FAIL %s[%0d]: got State=%b CEn=%b Running=%b ClrOut=%b, want State=%b CEn=%b Running=%b ClrOut=%b",
               name, idx, State, CEn, Running, ClrOut, es, er, er, ec);
    end
  endtask

  task automatic cyc(input logic st, input logic sp, input logic cl);
    Start = st;
    Stop  = sp;
    Clear = cl;
    @(posedge SysClk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Start    = 1'b0;
    Stop     = 1'b0;
    Clear    = 1'b0;
    Reset_n  = 1'b0;

    // Idle after reset
    push(0, 0, 0, SI, 0, 20);
    // Bounce, then a clean hold: RUN on the 7th edge after the final rise
    push(1, 0, 0, SI, 0, 2);
    push(0, 0, 0, SI, 0, 2);
    push(1, 0, 0, SI, 0, 2);
    push(0, 0, 0, SI, 0, 2);
    push(1, 0, 0, SI, 0, 6);
    push(1, 0, 0, SR, 0, 4);
    push(0, 0, 0, SR, 0, 8);
    // Re-press Start in RUN: no change
    push(1, 0, 0, SR, 0, 8);
    push(0, 0, 0, SR, 0, 8);
    // Stop -> PAUSE
    push(0, 1, 0, SR, 0, 6);
    push(0, 1, 0, SP, 0, 2);
    push(0, 0, 0, SP, 0, 8);
    // Clear from PAUSE -> IDLE with one-cycle pulse
    push(0, 0, 1, SP, 0, 6);
    push(0, 0, 1, SI, 1, 1);
    push(0, 0, 1, SI, 0, 1);
    push(0, 0, 0, SI, 0, 8);
    // Clear in IDLE: stays IDLE, pulse
    push(0, 0, 1, SI, 0, 6);
    push(0, 0, 1, SI, 1, 1);
    push(0, 0, 1, SI, 0, 1);
    push(0, 0, 0, SI, 0, 8);
    // Start -> RUN, then Clear in RUN is ignored
    push(1, 0, 0, SI, 0, 6);
    push(1, 0, 0, SR, 0, 2);
    push(0, 0, 0, SR, 0, 8);
    push(0, 0, 1, SR, 0, 8);
    push(0, 0, 0, SR, 0, 8);
    // RUN: Start+Stop together -> PAUSE
    push(1, 1, 0, SR, 0, 6);
    push(1, 1, 0, SP, 0, 2);
    push(0, 0, 0, SP, 0, 8);
    // PAUSE: Start+Clear together -> IDLE + pulse
    push(1, 0, 1, SP, 0, 6);
    push(1, 0, 1, SI, 1, 1);
    push(1, 0, 1, SI, 0, 1);
    push(0, 0, 0, SI, 0, 8);
    // IDLE: Start+Clear together -> RUN, no pulse
    push(1, 0, 1, SI, 0, 6);
    push(1, 0, 1, SR, 0, 2);
    push(0, 0, 0, SR, 0, 8);

    repeat (3) @(posedge SysClk);
    #1;
    check("reset_hold", 0, SI, 1'b0);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].st, vecs[i].sp, vecs[i].cl);
      check("vec", i, vecs[i].state, vecs[i].clr);
    end

    // Async reset while in RUN takes effect before the next clock edge
    @(posedge SysClk);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_rst_run", 0, SI, 1'b0);
    @(posedge SysClk);
    #1;

    // Start held through reset release: fresh press, RUN on the 7th edge
    Start   = 1'b1;
    Reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 0);
      check("held_rel", k, SI, 1'b0);
    end
    cyc(1, 0, 0);
    check("held_rel", 7, SR, 1'b0);
    cyc(1, 0, 0);
    check("held_rel", 8, SR, 1'b0);

    // Async reset mid-debounce of Stop
    Start = 1'b0;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_db", 0, SI, 1'b0);
    @(posedge SysClk);
    #1;
    Reset_n = 1'b1;
    // Stop held through release is a fresh press but IDLE ignores it
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 0);
      check("stop_after_rst", k, SI, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
